gpio_intr_ctrl: RTL and testbench
=================================

// Module: gpio_intr_ctrl
// PURPOSE
//  Register-mapped GPIO controller directly upstream of the pad mux: drives pad_gpio_out and cfg_gpio_dir_sel into it.
//  Consumes pad_gpio_in from it; synchronises (optionally filters) inputs, detects edges, raises a maskable interrupt.
//  Sits on the peripheral register bus beside the other port controllers.
// PARAMETERS
//  GPIO_W       32  number of GPIO bits (port A..D, 8 each)
//  SYNC_STAGES  2   input synchroniser depth, legal 2..3
//  FILT_LEN     4   consecutive equal samples needed to accept a level (GPIO_FILT_EN only), legal 2..8
// PORTS
//  mclk              in   1       single clock; all state on rising edge
//  reset             in   1       synchronous, active-high reset
//  reg_cs            in   1       register request; held until reg_ack
//  reg_wr            in   1       1=write 0=read
//  reg_addr          in   4       word index
//  reg_be            in   4       byte enables (writes)
//  reg_wdata         in   32      write data
//  reg_rdata         out  32      read data, valid with reg_ack
//  reg_ack           out  1       one-cycle completion pulse
//  pad_gpio_in       in   GPIO_W  raw pad levels from pin mux (asynchronous)
//  pad_gpio_out      out  GPIO_W  OUT register to pin mux
//  cfg_gpio_dir_sel  out  GPIO_W  DIR register to pin mux, 1=output
//  gpio_intr         out  1       |(INT_STAT & INT_MASK), registered
// BEHAVIOUR
//  Reset: all registers, reg_rdata, reg_ack, gpio_intr, sync/filter flops = 0; a request in flight is dropped, no ack.
//  Bus: reg_ack=1 the cycle after reg_cs&!reg_ack sampled; ack never two cycles back-to-back; min 2 cycles/access.
//  Map: 0 DIR RW; 1 OUT RW; 2 IN RO (conditioned level); 3 OUT_SET WO (1s set OUT); 4 OUT_CLR WO (1s clear OUT);
//   5 POS_EN RW; 6 NEG_EN RW; 7 INT_STAT RW1C; 8 INT_MASK RW. Unmapped/WO reads return 0; unmapped writes ignored, still acked.
//  Byte enables gate every write incl. SET/CLR/W1C; bits >= GPIO_W read 0, writes ignored.
//  Write takes effect on the ack cycle: pad_gpio_out/cfg_gpio_dir_sel change at the same edge reg_ack rises.
//  Input path: pad_gpio_in -> SYNC_STAGES flops -> [filter] -> gpio_lvl; gpio_lvl_d = gpio_lvl delayed 1 cycle.
//  rise = gpio_lvl & ~gpio_lvl_d & POS_EN; fall = ~gpio_lvl & gpio_lvl_d & NEG_EN; INT_STAT |= rise|fall each cycle.
//  Warm-up: counter after reset release suppresses rise/fall for SYNC_STAGES+1 cycles (+FILT_LEN with filter);
//   pins already high at reset exit do not set INT_STAT.
//  Simultaneous W1C and new edge on same bit: set wins (bit stays 1).
//  gpio_intr updates 1 cycle after INT_STAT/INT_MASK change; latency pad edge -> gpio_intr = SYNC_STAGES+2 cycles (no filter).
//  Clearing POS_EN/NEG_EN does not clear pending INT_STAT bits; masking only gates gpio_intr.
// CONFIGURATION
//  GPIO_FILT_EN defined: per-bit glitch filter after synchroniser; gpio_lvl changes only after FILT_LEN
//   consecutive equal synced samples (3-bit counter per bit, saturates); adds FILT_LEN cycles latency.
//  GPIO_FILT_EN undefined: gpio_lvl = synchroniser output; no filter flops; FILT_LEN unused.
// STRUCTURE
//  gpio_pkg: GPIO_W default, register index localparams (GPIO_DIR..GPIO_INT_MASK), gpio_reg_e enum.
//  Sub-module gpio_sync_filt: one bit of synchroniser + optional filter, generated GPIO_W times.
//  Top holds register file, bus FSM (IDLE->ACK->IDLE), edge detect, warm-up counter, interrupt reduce.
// TESTING
//  Reset with pad_gpio_in=32'hFFFF_FFFF, POS_EN=all -> INT_STAT stays 0, IN reads FFFF_FFFF.
//  Write OUT=32'h0000_00F0, OUT_SET=32'h0F, OUT_CLR=32'h30 -> pad_gpio_out=32'h0000_00CF; read OUT=CF, OUT_SET reads 0.
//  POS_EN[21]=1, MASK[21]=1, pin 21 0->1 -> INT_STAT=32'h0020_0000, gpio_intr high SYNC_STAGES+2 cycles after edge.
//  W1C INT_STAT bit 21 on same cycle as new edge on 21 -> bit remains 1; W1C with reg_be=4'b1011 -> bit 21 not cleared.
//  Reset asserted while reg_cs=1 -> no reg_ack, all outputs 0 next cycle; request re-issued after reset acked normally.
//  GPIO_FILT_EN, FILT_LEN=4: 2-cycle pulse on pin 5 -> IN[5]=0, no interrupt; 6-cycle pulse -> IN[5] rises, INT_STAT[5]=1.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants, register map and bus FSM states for the GPIO interrupt controller
package gpio_pkg;

    localparam int GPIO_W_DEF = 32;

    localparam logic [3:0] GPIO_DIR      = 4'd0;
    localparam logic [3:0] GPIO_OUT      = 4'd1;
    localparam logic [3:0] GPIO_IN       = 4'd2;
    localparam logic [3:0] GPIO_OUT_SET  = 4'd3;
    localparam logic [3:0] GPIO_OUT_CLR  = 4'd4;
    localparam logic [3:0] GPIO_POS_EN   = 4'd5;
    localparam logic [3:0] GPIO_NEG_EN   = 4'd6;
    localparam logic [3:0] GPIO_INT_STAT = 4'd7;
    localparam logic [3:0] GPIO_INT_MASK = 4'd8;

    typedef enum logic [3:0] {
        REG_DIR      = GPIO_DIR,
        REG_OUT      = GPIO_OUT,
        REG_IN       = GPIO_IN,
        REG_OUT_SET  = GPIO_OUT_SET,
        REG_OUT_CLR  = GPIO_OUT_CLR,
        REG_POS_EN   = GPIO_POS_EN,
        REG_NEG_EN   = GPIO_NEG_EN,
        REG_INT_STAT = GPIO_INT_STAT,
        REG_INT_MASK = GPIO_INT_MASK
    } gpio_reg_e;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } gpio_bus_state_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_if.sv
// rtl/gpio_if.sv - peripheral register bus between the bus master and the GPIO controller
interface gpio_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_be, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_be, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/gpio_sync_filt.sv
// rtl/gpio_sync_filt.sv - one pad bit: synchroniser plus glitch filter when GPIO_FILT_EN is defined
module gpio_sync_filt #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_FILT_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic mclk,
    input  logic reset,
    input  logic i_pad,
    output logic o_lvl
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

`ifdef GPIO_FILT_EN
    logic [2:0] r_cnt;
    logic       r_lvl;

    // counts consecutive samples disagreeing with the accepted level
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1] == r_lvl) begin
            r_cnt <= '0;
        end else if (r_cnt == 3'(FILT_LEN - 1)) begin
            r_lvl <= r_sync[SYNC_STAGES-1];
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_lvl = r_lvl;
`else
    assign o_lvl = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_intr_ctrl.sv
// rtl/gpio_intr_ctrl.sv - GPIO register file, edge detect and maskable interrupt; GPIO_FILT_EN adds input filtering
module gpio_intr_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = GPIO_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic              mclk,
    input  logic              reset,
    gpio_if.slave             bus,
    input  logic [GPIO_W-1:0] pad_gpio_in,
    output logic [GPIO_W-1:0] pad_gpio_out,
    output logic [GPIO_W-1:0] cfg_gpio_dir_sel,
    output logic              gpio_intr
);

`ifdef GPIO_FILT_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int WARM_CYC = SYNC_STAGES + 1 + (FILT_EN ? FILT_LEN : 0);

    gpio_bus_state_e r_state, w_state_nxt;
    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    gpio_reg_e         w_addr;
    logic [31:0]       w_be_mask32;
    logic [GPIO_W-1:0] w_be_mask;
    logic [GPIO_W-1:0] w_wd;
    logic [GPIO_W-1:0] w_w1c;
    logic [31:0]       w_rd_val;

    logic [GPIO_W-1:0] r_dir, r_out, r_pos_en, r_neg_en, r_int_stat, r_int_mask;
    logic [31:0]       r_rdata;
    logic              r_intr;
    logic [GPIO_W-1:0] w_lvl, r_lvl_d, w_rise, w_fall;
    logic [3:0]        r_warm;
    logic              w_warm_done;

    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_bit
        gpio_sync_filt #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_FILT_EN
            ,
            .FILT_LEN(FILT_LEN)
`endif
        ) u_sync_filt (
            .mclk (mclk),
            .reset(reset),
            .i_pad(pad_gpio_in[gi]),
            .o_lvl(w_lvl[gi])
        );
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (bus.reg_cs) begin
                    w_state_nxt = BUS_ACK;
                    w_access    = 1'b1;
                end
            end
            BUS_ACK:  w_state_nxt = BUS_IDLE;
            default:  w_state_nxt = BUS_IDLE;
        endcase
    end

    assign w_wr        = w_access & bus.reg_wr;
    assign w_rd        = w_access & ~bus.reg_wr;
    assign w_addr      = gpio_reg_e'(bus.reg_addr);
    assign w_be_mask32 = be_to_mask(bus.reg_be);
    assign w_be_mask   = w_be_mask32[GPIO_W-1:0];
    assign w_wd        = bus.reg_wdata[GPIO_W-1:0] & w_be_mask;
    assign w_w1c       = (w_wr && w_addr == REG_INT_STAT) ? w_wd : '0;

    always_comb begin
        w_rd_val = '0;
        case (w_addr)
            REG_DIR:      w_rd_val[GPIO_W-1:0] = r_dir;
            REG_OUT:      w_rd_val[GPIO_W-1:0] = r_out;
            REG_IN:       w_rd_val[GPIO_W-1:0] = w_lvl;
            REG_POS_EN:   w_rd_val[GPIO_W-1:0] = r_pos_en;
            REG_NEG_EN:   w_rd_val[GPIO_W-1:0] = r_neg_en;
            REG_INT_STAT: w_rd_val[GPIO_W-1:0] = r_int_stat;
            REG_INT_MASK: w_rd_val[GPIO_W-1:0] = r_int_mask;
            default:      w_rd_val = '0;
        endcase
    end

    // warm-up hides the spurious edge seen while the synchroniser fills after reset
    assign w_warm_done = (r_warm == 4'(WARM_CYC));
    assign w_rise      = w_lvl & ~r_lvl_d & r_pos_en & {GPIO_W{w_warm_done}};
    assign w_fall      = ~w_lvl & r_lvl_d & r_neg_en & {GPIO_W{w_warm_done}};

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_pos_en   <= '0;
            r_neg_en   <= '0;
            r_int_stat <= '0;
            r_int_mask <= '0;
            r_rdata    <= '0;
            r_intr     <= 1'b0;
            r_lvl_d    <= '0;
            r_warm     <= '0;
        end else begin
            r_lvl_d <= w_lvl;
            if (!w_warm_done) begin
                r_warm <= r_warm + 4'd1;
            end
            r_rdata    <= w_rd ? w_rd_val : '0;
            r_intr     <= |(r_int_stat & r_int_mask);
            // a new edge on the same cycle as a W1C keeps the bit set
            r_int_stat <= (r_int_stat & ~w_w1c) | w_rise | w_fall;
            if (w_wr) begin
                case (w_addr)
                    REG_DIR:      r_dir      <= (r_dir & ~w_be_mask) | w_wd;
                    REG_OUT:      r_out      <= (r_out & ~w_be_mask) | w_wd;
                    REG_OUT_SET:  r_out      <= r_out | w_wd;
                    REG_OUT_CLR:  r_out      <= r_out & ~w_wd;
                    REG_POS_EN:   r_pos_en   <= (r_pos_en & ~w_be_mask) | w_wd;
                    REG_NEG_EN:   r_neg_en   <= (r_neg_en & ~w_be_mask) | w_wd;
                    REG_INT_MASK: r_int_mask <= (r_int_mask & ~w_be_mask) | w_wd;
                    default:      ;
                endcase
            end
        end
    end

    assign bus.reg_ack      = (r_state == BUS_ACK);
    assign bus.reg_rdata    = r_rdata;
    assign pad_gpio_out     = r_out;
    assign cfg_gpio_dir_sel = r_dir;
    assign gpio_intr        = r_intr;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// tb/tb_gpio_intr_ctrl.sv - directed self-checking bench for gpio_intr_ctrl
module tb_gpio_intr_ctrl;
    import gpio_pkg::*;

    logic        mclk = 1'b0;
    logic        reset;
    logic [31:0] pad_gpio_in;
    logic [31:0] pad_gpio_out;
    logic [31:0] cfg_gpio_dir_sel;
    logic        gpio_intr;
    logic [31:0] rd_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    gpio_if u_bus ();

    gpio_intr_ctrl #(
        .GPIO_W(32),
        .SYNC_STAGES(2),
        .FILT_LEN(4)
    ) u_dut (
        .mclk            (mclk),
        .reset           (reset),
        .bus             (u_bus),
        .pad_gpio_in     (pad_gpio_in),
        .pad_gpio_out    (pad_gpio_out),
        .cfg_gpio_dir_sel(cfg_gpio_dir_sel),
        .gpio_intr       (gpio_intr)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic bus_access(input logic wr, input logic [3:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        u_bus.reg_cs    = 1'b1;
        u_bus.reg_wr    = wr;
        u_bus.reg_addr  = addr;
        u_bus.reg_be    = be;
        u_bus.reg_wdata = wdata;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge mclk);
            #1;
            if (u_bus.reg_ack) begin
                got   = 1'b1;
                rdata = u_bus.reg_rdata;
            end
        end
        u_bus.reg_cs = 1'b0;
        if (!got) check("bus_ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
        logic [31:0] dummy;
        bus_access(1'b1, addr, be, data, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_access(1'b0, addr, 4'hF, 32'h0, d);
        check(tag, d, exp);
    endtask

    initial begin
        reset           = 1'b1;
        pad_gpio_in     = 32'hFFFF_FFFF;
        u_bus.reg_cs    = 1'b0;
        u_bus.reg_wr    = 1'b0;
        u_bus.reg_addr  = 4'd0;
        u_bus.reg_be    = 4'd0;
        u_bus.reg_wdata = 32'd0;
        tick(3);
        check("rst_out", pad_gpio_out, 32'h0);
        check("rst_dir", cfg_gpio_dir_sel, 32'h0);
        check("rst_intr", 32'(gpio_intr), 32'h0);
        check("rst_ack", 32'(u_bus.reg_ack), 32'h0);
        check("rst_rdata", u_bus.reg_rdata, 32'h0);
        reset = 1'b0;
        tick(10);

        wr(GPIO_POS_EN, 4'hF, 32'hFFFF_FFFF);
        tick(5);
        rd_chk("stat_after_rst_high", GPIO_INT_STAT, 32'h0);
        rd_chk("in_all_high", GPIO_IN, 32'hFFFF_FFFF);

        wr(GPIO_DIR, 4'hF, 32'h0000_00FF);
        check("dir_pin", cfg_gpio_dir_sel, 32'h0000_00FF);
        rd_chk("dir_rd", GPIO_DIR, 32'h0000_00FF);

        wr(GPIO_OUT, 4'hF, 32'h0000_00F0);
        check("out_on_ack", pad_gpio_out, 32'h0000_00F0);
        wr(GPIO_OUT_SET, 4'hF, 32'h0000_000F);
        wr(GPIO_OUT_CLR, 4'hF, 32'h0000_0030);
        check("out_set_clr_pin", pad_gpio_out, 32'h0000_00CF);
        rd_chk("out_rd", GPIO_OUT, 32'h0000_00CF);
        rd_chk("out_set_rd0", GPIO_OUT_SET, 32'h0);
        wr(GPIO_OUT, 4'b0001, 32'hFFFF_FFFF);
        check("out_be_byte0", pad_gpio_out, 32'h0000_00FF);
        wr(GPIO_OUT_CLR, 4'b1110, 32'hFFFF_FFFF);
        check("clr_be_gated", pad_gpio_out, 32'h0000_00FF);

        pad_gpio_in = 32'h0;
        tick(5);
        wr(GPIO_POS_EN, 4'hF, 32'h0020_0000);
        wr(GPIO_INT_STAT, 4'hF, 32'hFFFF_FFFF);
        rd_chk("stat_clear", GPIO_INT_STAT, 32'h0);
        wr(GPIO_INT_MASK, 4'hF, 32'h0020_0000);

        pad_gpio_in = 32'h0020_0000;
        tick(3);
        check("intr_lat_minus1", 32'(gpio_intr), 32'h0);
        tick(1);
        check("intr_lat", 32'(gpio_intr), 32'h1);
        rd_chk("stat_pos21", GPIO_INT_STAT, 32'h0020_0000);
        rd_chk("in_pin21", GPIO_IN, 32'h0020_0000);

        wr(GPIO_INT_MASK, 4'hF, 32'h0);
        tick(1);
        check("intr_masked", 32'(gpio_intr), 32'h0);
        wr(GPIO_INT_MASK, 4'hF, 32'h0020_0000);
        tick(1);
        check("intr_unmasked", 32'(gpio_intr), 32'h1);

        wr(GPIO_INT_STAT, 4'b1011, 32'h0020_0000);
        rd_chk("w1c_be_gated", GPIO_INT_STAT, 32'h0020_0000);
        wr(GPIO_POS_EN, 4'hF, 32'h0);
        rd_chk("stat_kept_pos_off", GPIO_INT_STAT, 32'h0020_0000);
        wr(GPIO_POS_EN, 4'hF, 32'h0020_0000);

        pad_gpio_in = 32'h0;
        tick(5);
        wr(GPIO_INT_STAT, 4'hF, 32'h0020_0000);
        rd_chk("w1c_clears", GPIO_INT_STAT, 32'h0);
        tick(1);
        check("intr_after_w1c", 32'(gpio_intr), 32'h0);

        // new edge lands on the same edge as the W1C write
        pad_gpio_in = 32'h0020_0000;
        tick(2);
        u_bus.reg_cs    = 1'b1;
        u_bus.reg_wr    = 1'b1;
        u_bus.reg_addr  = GPIO_INT_STAT;
        u_bus.reg_be    = 4'hF;
        u_bus.reg_wdata = 32'h0020_0000;
        tick(1);
        check("collide_ack", 32'(u_bus.reg_ack), 32'h1);
        u_bus.reg_cs = 1'b0;
        rd_chk("set_wins", GPIO_INT_STAT, 32'h0020_0000);

        wr(GPIO_NEG_EN, 4'hF, 32'h0020_0000);
        wr(GPIO_INT_STAT, 4'hF, 32'h0020_0000);
        rd_chk("stat_clr2", GPIO_INT_STAT, 32'h0);
        pad_gpio_in = 32'h0;
        tick(6);
        rd_chk("stat_neg21", GPIO_INT_STAT, 32'h0020_0000);
        rd_chk("in_low", GPIO_IN, 32'h0);
        rd_chk("unmapped_rd", 4'd12, 32'h0);
        wr(4'd13, 4'hF, 32'hFFFF_FFFF);
        rd_chk("neg_en_rd", GPIO_NEG_EN, 32'h0020_0000);
        check("intr_before_rst", 32'(gpio_intr), 32'h1);

        u_bus.reg_cs    = 1'b1;
        u_bus.reg_wr    = 1'b1;
        u_bus.reg_addr  = GPIO_DIR;
        u_bus.reg_be    = 4'hF;
        u_bus.reg_wdata = 32'h0000_FFFF;
        reset           = 1'b1;
        tick(1);
        check("rst_cs_ack", 32'(u_bus.reg_ack), 32'h0);
        check("rst_cs_out", pad_gpio_out, 32'h0);
        check("rst_cs_dir", cfg_gpio_dir_sel, 32'h0);
        check("rst_cs_intr", 32'(gpio_intr), 32'h0);
        tick(1);
        check("rst_cs_ack2", 32'(u_bus.reg_ack), 32'h0);
        reset = 1'b0;
        bus_access(1'b1, GPIO_DIR, 4'hF, 32'h0000_FFFF, rd_data);
        check("reissue_dir", cfg_gpio_dir_sel, 32'h0000_FFFF);

`ifdef GPIO_FILT_EN
        tick(12);
        wr(GPIO_POS_EN, 4'hF, 32'h0000_0020);
        pad_gpio_in = 32'h0000_0020;
        tick(2);
        pad_gpio_in = 32'h0;
        tick(12);
        rd_chk("filt_short_in", GPIO_IN, 32'h0);
        rd_chk("filt_short_stat", GPIO_INT_STAT, 32'h0);
        pad_gpio_in = 32'h0000_0020;
        tick(6);
        pad_gpio_in = 32'h0;
        tick(12);
        rd_chk("filt_long_stat", GPIO_INT_STAT, 32'h0000_0020);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
